// File: rtl/ebab_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ebab_bus_arbiter
//  Two-requester round-robin arbiter for the external Avalon bus-master
//  bridge (EBAB) port. Requester 0 is the video-in -> VGA pixel-copy engine,
//  requester 1 is the key-highlight overlay drawer. One read or write is in
//  flight on the bridge at a time.
//
//  Optional feature: define EBAB_ARB_TIMEOUT_EN to build a bus-ack watchdog
//  that aborts a transaction after TIMEOUT_CYC cycles in BUSY.
//
//  Ports
//   CLOCK_50, RESET_N          clock, synchronous active-low reset
//   rqN_addr/byte_enable       requester address and byte mask
//   rqN_read/write             requester strobes, held until rqN_ack
//   rqN_write_data             requester write data
//   rqN_ack                    one-cycle completion pulse
//   rqN_read_data              read data, held between acks
//   bus_*                      registered bridge master interface
//   bus_ack, bus_read_data     bridge acknowledge and read data
//   grant                      index of current/last granted requester
//   stray_ack                  sticky: bus_ack seen outside BUSY
//   timeout_flag               sticky: watchdog abort occurred
// ---------------------------------------------------------------------------
module ebab_bus_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned BE_W        = 4,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,

   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [BE_W-1:0]   rq0_byte_enable,
   input  logic              rq0_read,
   input  logic              rq0_write,
   input  logic [DATA_W-1:0] rq0_write_data,
   output logic              rq0_ack,
   output logic [DATA_W-1:0] rq0_read_data,

   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic [BE_W-1:0]   rq1_byte_enable,
   input  logic              rq1_read,
   input  logic              rq1_write,
   input  logic [DATA_W-1:0] rq1_write_data,
   output logic              rq1_ack,
   output logic [DATA_W-1:0] rq1_read_data,

   output logic [ADDR_W-1:0] bus_addr,
   output logic [BE_W-1:0]   bus_byte_enable,
   output logic              bus_read,
   output logic              bus_write,
   output logic [DATA_W-1:0] bus_write_data,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_read_data,

   output logic              grant,
   output logic              stray_ack,
   output logic              timeout_flag
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic              last_grant, last_grant_nx;
   logic              grant_nx;
   logic [ADDR_W-1:0] bus_addr_nx;
   logic [BE_W-1:0]   bus_byte_enable_nx;
   logic              bus_read_nx, bus_write_nx;
   logic [DATA_W-1:0] bus_write_data_nx;
   logic              rq0_ack_nx, rq1_ack_nx;
   logic [DATA_W-1:0] rq0_read_data_nx, rq1_read_data_nx;
   logic              stray_ack_nx;

   // Request decode and round-robin selection
   logic              req0_c, req1_c, sel_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [BE_W-1:0]   sel_be_c;
   logic [DATA_W-1:0] sel_wdata_c;
   logic              sel_read_c, sel_write_c;

   assign req0_c      = rq0_read | rq0_write;
   assign req1_c      = rq1_read | rq1_write;
   // On a tie the requester that did not win last time goes first.
   assign sel_c       = (req0_c & req1_c) ? ~last_grant : req1_c;
   assign sel_addr_c  = sel_c ? rq1_addr        : rq0_addr;
   assign sel_be_c    = sel_c ? rq1_byte_enable : rq0_byte_enable;
   assign sel_wdata_c = sel_c ? rq1_write_data  : rq0_write_data;
   assign sel_write_c = sel_c ? rq1_write       : rq0_write;
   // Read+write together is treated as a write.
   assign sel_read_c  = (sel_c ? rq1_read : rq0_read) & ~sel_write_c;

`ifdef EBAB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;
   localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

   logic [CNT_W-1:0] wd_cnt, wd_cnt_nx;
   logic             timeout_flag_nx;
`else
   logic unused_timeout_c;
   assign unused_timeout_c = ^{32'(TIMEOUT_CYC)};
   assign timeout_flag     = 1'b0;
`endif

   // Completion of the granted transaction (bus ack or watchdog abort)
   logic              done_c;
   logic [DATA_W-1:0] done_data_c;

   // Next-state and registered-output logic
   always_comb begin
      state_nx           = state;
      last_grant_nx      = last_grant;
      grant_nx           = grant;
      bus_addr_nx        = bus_addr;
      bus_byte_enable_nx = bus_byte_enable;
      bus_read_nx        = bus_read;
      bus_write_nx       = bus_write;
      bus_write_data_nx  = bus_write_data;
      rq0_ack_nx         = 1'b0;
      rq1_ack_nx         = 1'b0;
      rq0_read_data_nx   = rq0_read_data;
      rq1_read_data_nx   = rq1_read_data;
      stray_ack_nx       = stray_ack | (bus_ack & (state != ST_BUSY));
      done_c             = 1'b0;
      done_data_c        = bus_read_data;
`ifdef EBAB_ARB_TIMEOUT_EN
      wd_cnt_nx          = wd_cnt;
      timeout_flag_nx    = timeout_flag;
`endif

      case (state)
         ST_IDLE: begin
            if (req0_c | req1_c) begin
               bus_addr_nx        = sel_addr_c;
               bus_byte_enable_nx = sel_be_c;
               bus_write_data_nx  = sel_wdata_c;
               bus_read_nx        = sel_read_c;
               bus_write_nx       = sel_write_c;
               grant_nx           = sel_c;
               last_grant_nx      = sel_c;
               state_nx           = ST_BUSY;
`ifdef EBAB_ARB_TIMEOUT_EN
               wd_cnt_nx          = '0;
`endif
            end
         end

         ST_BUSY: begin
            if (bus_ack) begin
               done_c = 1'b1;
`ifdef EBAB_ARB_TIMEOUT_EN
            end else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               // Bridge never answered: abort with a recognisable pattern.
               done_c          = 1'b1;
               done_data_c     = TIMEOUT_DATA;
               timeout_flag_nx = 1'b1;
            end else begin
               wd_cnt_nx = wd_cnt + CNT_W'(1);
`endif
            end
         end

         ST_ACK: begin
            state_nx = ST_IDLE;
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      if (done_c) begin
         bus_read_nx  = 1'b0;
         bus_write_nx = 1'b0;
         state_nx     = ST_ACK;
         if (grant) begin
            rq1_ack_nx       = 1'b1;
            rq1_read_data_nx = done_data_c;
         end else begin
            rq0_ack_nx       = 1'b1;
            rq0_read_data_nx = done_data_c;
         end
      end
   end

   // State and output registers
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state           <= ST_IDLE;
         last_grant      <= 1'b1;
         grant           <= 1'b0;
         bus_addr        <= '0;
         bus_byte_enable <= '0;
         bus_read        <= 1'b0;
         bus_write       <= 1'b0;
         bus_write_data  <= '0;
         rq0_ack         <= 1'b0;
         rq1_ack         <= 1'b0;
         rq0_read_data   <= '0;
         rq1_read_data   <= '0;
         stray_ack       <= 1'b0;
`ifdef EBAB_ARB_TIMEOUT_EN
         wd_cnt          <= '0;
         timeout_flag    <= 1'b0;
`endif
      end else begin
         state           <= state_nx;
         last_grant      <= last_grant_nx;
         grant           <= grant_nx;
         bus_addr        <= bus_addr_nx;
         bus_byte_enable <= bus_byte_enable_nx;
         bus_read        <= bus_read_nx;
         bus_write       <= bus_write_nx;
         bus_write_data  <= bus_write_data_nx;
         rq0_ack         <= rq0_ack_nx;
         rq1_ack         <= rq1_ack_nx;
         rq0_read_data   <= rq0_read_data_nx;
         rq1_read_data   <= rq1_read_data_nx;
         stray_ack       <= stray_ack_nx;
`ifdef EBAB_ARB_TIMEOUT_EN
         wd_cnt          <= wd_cnt_nx;
         timeout_flag    <= timeout_flag_nx;
`endif
      end
   end

endmodule
